// File: rtl/data_sram_resp_pkg.sv
// Shared CPU-side defines for the data SRAM responder: config region base,
// register offsets, read-source select and a byte-lane merge helper.
package data_sram_resp_pkg;

    localparam logic [15:0] CONF_BASE  = 16'hBFAF;
    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_SWITCH = 16'hF010;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;

    typedef enum logic {
        SRC_RAM = 1'b0,
        SRC_CFG = 1'b1
    } rsrc_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// CPU data-SRAM port: single-cycle request, registered read data next cycle.
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
                    input  data_sram_rdata);
    modport slave  (input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
                    output data_sram_rdata);
endinterface

// File: rtl/data_sram_resp_ram_bytewe.sv
// 2^AW x 32 synchronous RAM, per-byte write enables, registered read port
// returning the word as it was before a same-cycle write.
module ram_bytewe #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            for (int b = 0; b < 4; b++)
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: decodes RAM vs config region, holds LED/timer/switch
// registers and muxes the registered read data back to the CPU.
module data_sram_resp #(
    parameter int          RAM_AW    = 10,
    parameter logic [15:0] CONF_BASE = data_sram_resp_pkg::CONF_BASE
) (
    input  logic              clk,
    input  logic              reset,
    data_sram_resp_if.slave   bus,
    input  logic [7:0]        switch,
    output logic [15:0]       led,
    output logic [31:0]       timer
);
    import data_sram_resp_pkg::*;

    rsrc_e       r_src;
    logic [31:0] r_cfg_rdata;
    logic [31:0] r_timer;
    logic [15:0] r_led;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;

    logic        w_is_cfg;
    logic [15:0] w_off;
    logic        w_wr;
    logic        w_ram_en;
    logic        w_led_wr;
    logic        w_tmr_wr;
    logic [15:0] w_led_next;
    logic [31:0] w_cfg_rd;
    logic [31:0] w_ram_q;
    logic        w_unused_addr;

    assign w_is_cfg = (bus.data_sram_addr[31:16] == CONF_BASE);
    // Byte offset bits are don't-care for the config registers as well.
    assign w_off    = {bus.data_sram_addr[15:2], 2'b00};
    assign w_wr     = |bus.data_sram_we;
    assign w_ram_en = bus.data_sram_en & ~reset & ~w_is_cfg;
    assign w_led_wr = bus.data_sram_en & w_is_cfg & w_wr & (w_off == OFF_LED);
    assign w_tmr_wr = bus.data_sram_en & w_is_cfg & w_wr & (w_off == OFF_TIMER);
    assign w_unused_addr = ^bus.data_sram_addr[1:0];

    assign w_led_next = {bus.data_sram_we[1] ? bus.data_sram_wdata[15:8] : r_led[15:8],
                         bus.data_sram_we[0] ? bus.data_sram_wdata[7:0]  : r_led[7:0]};

    always_comb begin
        w_cfg_rd = 32'h0;
        case (w_off)
            OFF_LED:    w_cfg_rd = {16'h0, r_led};
            OFF_SWITCH: w_cfg_rd = {24'h0, r_sw_sync};
            OFF_TIMER:  w_cfg_rd = r_timer;
            default:    w_cfg_rd = 32'h0;
        endcase
    end

    ram_bytewe #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (bus.data_sram_we),
        .i_addr  (bus.data_sram_addr[RAM_AW+1:2]),
        .i_wdata (bus.data_sram_wdata),
        .o_rdata (w_ram_q)
    );

    // Reset parks the mux on the zeroed config path so rdata reads 0 without
    // needing a reset on the RAM output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src       <= SRC_CFG;
            r_cfg_rdata <= 32'h0;
            r_timer     <= 32'h0;
            r_led       <= 16'h0;
            r_sw_meta   <= 8'h0;
            r_sw_sync   <= 8'h0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
            r_timer   <= w_tmr_wr ? byte_merge(r_timer, bus.data_sram_wdata, bus.data_sram_we)
                                  : r_timer + 32'h1;
            if (w_led_wr) r_led <= w_led_next;
            if (bus.data_sram_en) begin
                r_src <= w_is_cfg ? SRC_CFG : SRC_RAM;
                if (w_is_cfg) r_cfg_rdata <= w_cfg_rd;
            end
        end
    end

    assign bus.data_sram_rdata = (r_src == SRC_RAM) ? w_ram_q : r_cfg_rdata;
    assign led   = r_led;
    assign timer = r_timer;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed + random bench for data_sram_resp against a cycle-level model
// built from the address map and register rules.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  switch = 8'h0;
    logic [15:0] led;
    logic [31:0] timer;

    data_sram_resp_if bus();

    data_sram_resp #(.RAM_AW(10), .CONF_BASE(16'hBFAF)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .switch (switch),
        .led    (led),
        .timer  (timer)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [31:0] m_mem [1024];
    bit          m_known [1024];
    logic [31:0] m_rdata = 32'h0;
    bit          m_rd_known = 1'b1;
    logic [15:0] m_led = 16'h0;
    logic [31:0] m_timer = 32'h0;
    logic [7:0]  sw_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic step(input bit rst, input bit en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic [31:0] t_next;
        logic [31:0] led_w;
        logic [15:0] off;
        logic [9:0]  idx;
        logic [7:0]  sync;
        bit          rd_known;
        reset               = rst;
        bus.data_sram_en    = en;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wd;
        if (rst) begin
            m_rdata = 32'h0; m_rd_known = 1'b1; m_led = 16'h0; m_timer = 32'h0;
            sw_q = '{8'h0, 8'h0};
        end else begin
            sync = sw_q[0];
            sw_q.push_back(switch);
            void'(sw_q.pop_front());
            t_next = m_timer + 32'd1;
            if (en) begin
                idx = addr[11:2];
                off = {addr[15:2], 2'b00};
                rd_known = 1'b1;
                if (addr[31:16] == 16'hBFAF) begin
                    case (off)
                        16'hF000: rd = {16'h0, m_led};
                        16'hF010: rd = {24'h0, sync};
                        16'hE000: rd = m_timer;
                        default:  rd = 32'h0;
                    endcase
                    if (off == 16'hF000) begin
                        led_w = merge({16'h0, m_led}, wd, {2'b00, we[1:0]});
                        m_led = led_w[15:0];
                    end
                    if (off == 16'hE000 && we != 4'h0) t_next = merge(m_timer, wd, we);
                end else begin
                    rd = m_mem[idx];
                    rd_known = m_known[idx];
                    m_mem[idx] = merge(m_mem[idx], wd, we);
                    if (we == 4'hF) m_known[idx] = 1'b1;
                end
                m_rdata = rd;
                m_rd_known = rd_known;
            end
            m_timer = t_next;
        end
        @(posedge clk);
        #1;
        if (m_rd_known) chk("model_rdata", bus.data_sram_rdata, m_rdata);
        chk("model_led", {16'h0, led}, {16'h0, m_led});
        chk("model_timer", timer, m_timer);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        sw_q = '{8'h0, 8'h0};
        bus.data_sram_en = 1'b0;
        bus.data_sram_we = 4'h0;
        bus.data_sram_addr = 32'h0;
        bus.data_sram_wdata = 32'h0;

        // Reset state
        step(1, 1, 4'hF, 32'h10, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        chk("reset_rdata", bus.data_sram_rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_timer", timer, 32'h0);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        chk("timer_after_reset", timer, 32'h1);

        // Full write then back-to-back read
        step(0, 1, 4'hF, 32'h0000_0010, 32'hDEADBEEF);
        step(0, 1, 4'h0, 32'h0000_0010, 32'h0);
        chk("wr_rd_b2b", bus.data_sram_rdata, 32'hDEADBEEF);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        chk("rdata_hold", bus.data_sram_rdata, 32'hDEADBEEF);

        // Partial write, read-before-write
        step(0, 1, 4'b0101, 32'h0000_0010, 32'h11223344);
        chk("rbw_old_word", bus.data_sram_rdata, 32'hDEADBEEF);
        step(0, 1, 4'h0, 32'h0000_0010, 32'h0);
        chk("byte_merge", bus.data_sram_rdata, 32'hDE22BE44);

        // LED register
        step(0, 1, 4'hF, 32'hBFAF_F000, 32'h0000A5A5);
        chk("led_write", {16'h0, led}, 32'h0000A5A5);
        step(0, 1, 4'h0, 32'hBFAF_F000, 32'h0);
        chk("led_read", bus.data_sram_rdata, 32'h0000A5A5);

        // Timer load and wrap
        step(0, 1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
        chk("timer_load", timer, 32'hFFFF_FFFE);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        chk("timer_max", timer, 32'hFFFF_FFFF);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        chk("timer_wrap", timer, 32'h0);

        // Switch synchronizer, unmapped offset, RO switch
        switch = 8'h3C;
        for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 32'h0, 32'h0);
        step(0, 1, 4'h0, 32'hBFAF_F010, 32'h0);
        chk("switch_read", bus.data_sram_rdata, 32'h0000_003C);
        step(0, 1, 4'h0, 32'hBFAF_F100, 32'h0);
        chk("unmapped_read", bus.data_sram_rdata, 32'h0);
        step(0, 1, 4'hF, 32'hBFAF_F010, 32'hFFFF_FFFF);
        step(0, 1, 4'h0, 32'hBFAF_F010, 32'h0);
        chk("switch_ro", bus.data_sram_rdata, 32'h0000_003C);

        // Reset mid-sequence with a write pending
        step(1, 1, 4'hF, 32'h0000_0010, 32'h0BAD_0BAD);
        chk("midrst_rdata", bus.data_sram_rdata, 32'h0);
        chk("midrst_led", {16'h0, led}, 32'h0);
        chk("midrst_timer", timer, 32'h0);
        step(0, 1, 4'h0, 32'h0000_0010, 32'h0);
        chk("midrst_ram_kept", bus.data_sram_rdata, 32'hDE22BE44);
        chk("midrst_timer_run", timer, 32'h1);

        // Random traffic against the model
        for (int w = 0; w < 16; w++)
            step(0, 1, 4'hF, 32'(w) << 2, $urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5:
                    a = ($urandom_range(0, 1) ? 32'h0004_0000 : 32'h0)
                        | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                6: a = 32'hBFAF_F000 | 32'($urandom_range(0, 3));
                7: a = 32'hBFAF_F010;
                8: a = 32'hBFAF_E000;
                default: a = {16'hBFAF, 16'($urandom)};
            endcase
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), we, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
